// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and sequencer for a parity-protected
// single-port RAM of 2**ADDR_W words x (DATA_W+1) bits.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req0/1, we0/1            request (held until granted), 1 = write / 0 = read
//   addr0/1, wdata0/1        command address and write payload
//   gnt0/1                   acceptance pulse, combinational in IDLE
//   rvalid0/1                one-cycle read-return pulse
//   rdata0/1, perr0/1        read payload and parity error, held until next return
//   mem_write, mem_read      RAM strobes (ISSUE only, never together)
//   mem_addr, mem_wdata      RAM address / payload, held outside ISSUE
//   mem_rdata                RAM output {parity, data}, valid the cycle after mem_read
//   err_count                saturating count of parity failures
//   busy                     high whenever the sequencer is not IDLE
module ram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              perr0,
  output logic              perr1,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W:0]   mem_rdata,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  // Port id of the most recent grant; doubles as the owner of the in-flight command.
  logic              last_grant_q;
  logic              we_q;
  logic              grant_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              perr_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: grants in IDLE, RAM strobes in ISSUE
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        // Gated by rst_n so grants are also held low while reset is asserted.
        if (rst_n) begin
          if (req0 && req1) begin
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      end
      ISSUE: begin
        mem_write = we_q;
        mem_read  = ~we_q;
      end
      default: ;
    endcase
  end

  // Granted port's command fields
  assign grant_c     = gnt0 | gnt1;
  assign sel_we_c    = gnt1 ? we1 : we0;
  assign sel_addr_c  = gnt1 ? addr1 : addr0;
  assign sel_wdata_c = gnt1 ? wdata1 : wdata0;

  // Even parity over the payload compared with the stored parity bit
  assign perr_c = (^mem_rdata[DATA_W-1:0]) != mem_rdata[DATA_W];

  // Command latch; mem_addr/mem_wdata load on grant and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else if (grant_c) begin
      last_grant_q <= gnt1;
      we_q         <= sel_we_c;
      mem_addr     <= sel_addr_c;
      if (sel_we_c) begin
        mem_wdata <= sel_wdata_c;
      end
    end
  end

  // Read return to the owner port and parity error accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0    <= '0;
      rdata1    <= '0;
      perr0     <= 1'b0;
      perr1     <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err_count <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (state_q == CAPTURE) begin
        if (last_grant_q) begin
          rdata1  <= mem_rdata[DATA_W-1:0];
          perr1   <= perr_c;
          rvalid1 <= 1'b1;
        end else begin
          rdata0  <= mem_rdata[DATA_W-1:0];
          perr0   <= perr_c;
          rvalid0 <= 1'b1;
        end
        if (perr_c && (err_count != {CNT_W{1'b1}})) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. A RAM stub with per-address
// parity corruption sits behind the DUT; a transaction-level timeline model predicts
// grants, strobes, returns and the error counter every cycle.
module tb_ram_arbiter;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, perr0, perr1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_write, mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W:0]   mem_rdata;
  logic [CNT_W-1:0]  err_count;
  logic              busy;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .perr0(perr0), .perr1(perr1),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM stub: stores correct even parity, optionally returns it inverted
  logic [DATA_W:0] ram     [0:(1<<ADDR_W)-1];
  bit              corrupt [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= {^mem_wdata, mem_wdata};
    if (mem_read)  mem_rdata <= ram[mem_addr] ^ {corrupt[mem_addr], {DATA_W{1'b0}}};
  end

  typedef struct {
    bit              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int              gap;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];
  cmd_t cur[2];
  bit   act[2];

  int checks, failures, cyc;
  // Timeline model: absolute cycle numbers of predicted events
  int free_cyc, wr_cyc, rd_cyc, rv_cyc, rv_port;
  logic [DATA_W-1:0] rv_data;
  bit                rv_perr;
  bit                last_g;
  logic [DATA_W-1:0] mdata [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] hold_rdata [2];
  bit                hold_perr [2];
  int                err_exp;
  logic [ADDR_W-1:0] exp_maddr;
  logic [DATA_W-1:0] exp_mwdata;
  logic [ADDR_W-1:0] pool [12];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    free_cyc = 0; wr_cyc = -1; rd_cyc = -1; rv_cyc = -1; rv_port = 0;
    last_g = 1'b1; err_exp = 0; exp_maddr = '0; exp_mwdata = '0;
    hold_rdata[0] = '0; hold_rdata[1] = '0; hold_perr[0] = 0; hold_perr[1] = 0;
    act[0] = 0; act[1] = 0;
  endtask

  task automatic push(input int p, input bit we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input int gap);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d; c.gap = gap;
    if (p == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  task automatic drive_port(input int p);
    if (!act[p]) begin
      if (p == 0 && q0.size() > 0) begin
        if (q0[0].gap > 0) q0[0].gap = q0[0].gap - 1;
        else begin cur[0] = q0.pop_front(); act[0] = 1; end
      end else if (p == 1 && q1.size() > 0) begin
        if (q1[0].gap > 0) q1[0].gap = q1[0].gap - 1;
        else begin cur[1] = q1.pop_front(); act[1] = 1; end
      end
    end
  endtask

  task automatic apply_pins();
    req0   = act[0];
    we0    = act[0] ? cur[0].we   : 1'($urandom);
    addr0  = act[0] ? cur[0].addr : ADDR_W'($urandom);
    wdata0 = act[0] ? cur[0].data : DATA_W'($urandom);
    req1   = act[1];
    we1    = act[1] ? cur[1].we   : 1'($urandom);
    addr1  = act[1] ? cur[1].addr : ADDR_W'($urandom);
    wdata1 = act[1] ? cur[1].data : DATA_W'($urandom);
  endtask

  // One clock: drive after the rising edge, check on the falling edge
  task automatic step();
    bit   g0, g1;
    int   p;
    cmd_t c;
    @(posedge clk); #1;
    drive_port(0); drive_port(1); apply_pins();
    @(negedge clk);
    cyc++;
    g0 = 0; g1 = 0;
    if (cyc >= free_cyc && (req0 || req1)) begin
      if (req0 && req1) begin g0 = last_g; g1 = !last_g; end
      else begin g0 = req0; g1 = req1; end
    end
    if (cyc == rv_cyc) begin
      hold_rdata[rv_port] = rv_data;
      hold_perr[rv_port]  = rv_perr;
      if (rv_perr && err_exp < int'(CNT_MAX)) err_exp++;
    end
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("mem_write", mem_write, cyc == wr_cyc);
    chk("mem_read", mem_read, cyc == rd_cyc);
    chk("rw_excl", mem_write && mem_read, 0);
    chk("busy", busy, cyc < free_cyc);
    chk("mem_addr", mem_addr, exp_maddr);
    chk("mem_wdata", mem_wdata, exp_mwdata);
    chk("rvalid0", rvalid0, cyc == rv_cyc && rv_port == 0);
    chk("rvalid1", rvalid1, cyc == rv_cyc && rv_port == 1);
    chk("rdata0", rdata0, hold_rdata[0]);
    chk("rdata1", rdata1, hold_rdata[1]);
    chk("perr0", perr0, hold_perr[0]);
    chk("perr1", perr1, hold_perr[1]);
    chk("err_count", err_count, err_exp);
    if (g0 || g1) begin
      p = g1 ? 1 : 0;
      c = cur[p];
      last_g = g1;
      exp_maddr = c.addr;
      if (c.we) begin
        exp_mwdata = c.data;
        mdata[c.addr] = c.data;
        wr_cyc = cyc + 1;
        free_cyc = cyc + 2;
      end else begin
        rd_cyc = cyc + 1;
        rv_cyc = cyc + 3;
        rv_port = p;
        rv_data = mdata.exists(c.addr) ? mdata[c.addr] : '0;
        rv_perr = corrupt[c.addr];
        free_cyc = cyc + 3;
      end
      act[p] = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] ||
            cyc < free_cyc || cyc < rv_cyc) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", n >= budget, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {gnt1, gnt0}, 0);
    chk({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
    chk({tag, "_perr"}, {perr1, perr0}, 0);
    chk({tag, "_rdata"}, {rdata1, rdata0}, 0);
    chk({tag, "_strobes"}, {mem_write, mem_read}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    clk = 0; checks = 0; failures = 0; cyc = 0;
    rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1;

    // Write then read back from port 0
    push(0, 1, 16'h1234, 8'hA5, 0);
    push(0, 0, 16'h1234, 8'h00, 0);
    drain(50);
    chk("t1_rdata0", rdata0, 8'hA5);
    chk("t1_perr0", perr0, 0);

    // Both ports reading concurrently: alternating grants
    push(0, 1, 16'h0001, 8'h11, 0);
    push(0, 1, 16'hFFFF, 8'hEE, 0);
    drain(50);
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 16'h0001, 8'h00, 0);
      push(1, 0, 16'hFFFF, 8'h00, 0);
    end
    drain(100);
    chk("t2_rdata0", rdata0, 8'h11);
    chk("t2_rdata1", rdata1, 8'hEE);

    // Lone requester after the other port: immediate grant, writes every 2 cycles
    push(0, 1, 16'h0100, 8'h5A, 0);
    push(1, 1, 16'h0200, 8'h01, 2);
    for (int i = 0; i < 3; i++) push(1, 1, 16'h0201 + 16'(i), 8'h02 + 8'(i), 0);
    drain(50);

    // Read-after-write across ports
    push(0, 1, 16'h0300, 8'h3C, 0);
    push(1, 0, 16'h0300, 8'h00, 1);
    drain(50);
    chk("raw_rdata1", rdata1, 8'h3C);

    // Parity failure, then saturation of the counter
    corrupt[16'h00A5] = 1;
    push(0, 1, 16'h00A5, 8'hA5, 0);
    push(0, 0, 16'h00A5, 8'h00, 0);
    drain(50);
    chk("par_perr0", perr0, 1);
    chk("par_err_one", err_count, 1);
    for (int i = 0; i < 10; i++) begin
      push(0, 0, 16'h00A5, 8'h00, 0);
      push(1, 0, 16'h00A5, 8'h00, 0);
    end
    drain(200);
    chk("par_err_sat", err_count, CNT_MAX);
    chk("par_perr1", perr1, 1);

    // Reset during CAPTURE of a read
    push(0, 0, 16'h1234, 8'h00, 0);
    n = 0;
    while (!(rv_cyc > 0 && cyc == rv_cyc - 1) && n < 20) begin step(); n++; end
    chk("rst_reach_capture", n >= 20, 0);
    rst_n = 0; req0 = 0; req1 = 0;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 chk_all_zero("midrst_hold");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    push(0, 0, 16'h1234, 8'h00, 0);
    drain(50);
    chk("post_rst_rdata0", rdata0, 8'hA5);

    // Randomized traffic over a written address pool
    for (int i = 0; i < 12; i++) begin
      pool[i] = ADDR_W'($urandom);
      corrupt[pool[i]] = (i < 3);
      push(0, 1, pool[i], DATA_W'($urandom), 0);
    end
    drain(100);
    for (int i = 0; i < 150; i++) begin
      push(0, 1'($urandom), pool[$urandom_range(0, 11)], DATA_W'($urandom), $urandom_range(0, 3));
      push(1, 1'($urandom), pool[$urandom_range(0, 11)], DATA_W'($urandom), $urandom_range(0, 3));
    end
    drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
